alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL derive local constant SHW = $clog2(XLEN) as the shift-amount width; SHW is not overridable.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, and all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset, asynchronous and active-high.
REQ-005 SHALL have ports i_valid (in, 1) and o_ready (out, 1); operation-request handshake.
REQ-006 SHALL have ports i_1 and i_2, each input, XLEN bits; the two operands.
REQ-007 SHALL have port aluSel, input, 5 bits; operation select.
REQ-008 SHALL have port i_flush, input, 1 bit; aborts any in-flight or held operation.
REQ-009 SHALL have ports o_valid (out, 1) and i_ready (in, 1); result handshake.
REQ-010 SHALL have port result, output, XLEN bits; the registered result.
REQ-011 SHALL have port zero_flag, output, 1 bit; asserted when result == 0.

Function
REQ-012 SHALL accept an operation when i_valid && o_ready.
REQ-013 SHALL drive o_ready = (state==IDLE) && (!o_valid || i_ready).
REQ-014 SHALL implement single-cycle codes 0_0000 AND, 0_0001 OR, 0_0010 XOR, 0_0011 ADD, 0_0100 SUB, 0_0110 pass i_2, 0_0111 SLL, 0_1000 SRL, 0_1001 SRA (true arithmetic, sign-filled), 0_1010 SLL-alias, 0_1011 SLTU, 0_1100 SLT.
REQ-015 SHALL use only i_2[SHW-1:0] as the shift amount.
REQ-016 SHALL zero-extend SLT/SLTU results to XLEN.
REQ-017 SHALL present single-cycle op results with o_valid high on the cycle after acceptance (latency 1).
REQ-018 SHALL, with back-to-back acceptance, sustain one single-cycle op per clock while i_ready is held high.
REQ-019 SHALL implement multi-cycle codes 1_0000 MUL, 1_0001 MULH, 1_0010 MULHSU, 1_0011 MULHU, 1_0100 DIV, 1_0101 DIVU, 1_0110 REM, 1_0111 REMU, with RISC-V M semantics generalised to XLEN.
REQ-020 SHALL use FSM states IDLE, BUSY and DONE for multi-cycle ops.
REQ-021 SHALL transition IDLE->BUSY on acceptance, and BUSY->DONE after exactly XLEN iteration cycles.
REQ-022 SHALL, in DONE, drive o_valid high, and transition DONE->IDLE on i_ready.
REQ-023 SHALL give multi-cycle ops a fixed latency of XLEN+1 cycles from acceptance to o_valid, including the special cases.
REQ-024 SHALL return all-ones as the quotient and the dividend as the remainder on divide by zero.
REQ-025 SHALL return quotient = dividend and remainder = 0 on signed overflow (-2^(XLEN-1) / -1).
REQ-026 SHALL accept undefined codes as single-cycle ops that return 0.
REQ-027 SHALL hold result and zero_flag stable while o_valid && !i_ready.
REQ-028 SHALL, on i_flush, in the next cycle clear o_valid, return the FSM to IDLE and discard the operation.
REQ-029 SHALL give i_flush priority over acceptance in the same cycle.
REQ-030 SHALL assert o_ready in the cycle after a flush.
REQ-031 SHALL compute zero_flag from the registered result, updating in the same cycle as result.

Reset
REQ-032 SHALL, while rst is high, asynchronously force state=IDLE, o_valid=0, result=0, zero_flag=1, and clear all iteration registers.
REQ-033 SHALL, on reset asserted mid-operation, abandon the operation with no o_valid pulse after release.
REQ-034 SHALL assert o_ready one cycle after rst deasserts.

Configuration
REQ-035 SHALL, with ALU_MULDIV_EN defined, instantiate the iterative multiply/divide unit with the behaviour in REQ-019..REQ-025.
REQ-036 SHALL, without ALU_MULDIV_EN, omit the unit and the BUSY/DONE states, and treat codes 1_0xxx as undefined (latency 1, result 0).

Structure
REQ-037 SHALL place the opcode localparams/enum (alu_op_t) and the FSM state type in the shared package alu_pkg.
REQ-038 SHALL implement the radix-2 shift-add multiplier and restoring divider as sub-module alu_muldiv_iter (XLEN parameter; start/done interface), instantiated only under ALU_MULDIV_EN.

Verification
REQ-039 SHALL verify back-to-back single-cycle ops: XLEN=32, ADD 7+(-7) then SRA 0x80000000>>4 with i_ready=1 -> result 0 with zero_flag=1, then 0xF8000000 with zero_flag=0, one per cycle.
REQ-040 SHALL verify backpressure: SUB 5-3 with i_ready=0 for 3 cycles -> result 2 held, o_ready=0, o_valid=1, until i_ready.
REQ-041 SHALL verify MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE with o_valid exactly 33 cycles after acceptance.
REQ-042 SHALL verify division special cases: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REMU 9/0 -> 9; DIVU 9/0 -> 0xFFFFFFFF.
REQ-043 SHALL verify flush and reset: i_flush in cycle 10 of a DIV -> no o_valid, o_ready=1 next cycle; rst mid-MUL -> outputs return to reset values immediately.
REQ-044 SHALL verify configuration: with ALU_MULDIV_EN undefined, MUL 3*4 -> result 0 at latency 1; with XLEN=16, SLL 1<<0x13 -> 0x0008.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM types for the pipelined ALU.
// Codes 1_0xxx are multiply/divide (only live with ALU_MULDIV_EN).
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND    = 5'h00,
    OP_OR     = 5'h01,
    OP_XOR    = 5'h02,
    OP_ADD    = 5'h03,
    OP_SUB    = 5'h04,
    OP_PASS   = 5'h06,
    OP_SLL    = 5'h07,
    OP_SRL    = 5'h08,
    OP_SRA    = 5'h09,
    OP_SLLA   = 5'h0A,
    OP_SLTU   = 5'h0B,
    OP_SLT    = 5'h0C,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MD_PFX = 2'b10;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 shift-add multiplier and restoring divider, XLEN steps.
// Instantiated by alu_pipe only when ALU_MULDIV_EN is defined.
module alu_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

  logic            busy;
  logic [SHW-1:0]  cnt;
  logic [2:0]      op_q;
  logic            neg_q, negr_q, div0_q;
  logic [XLEN-1:0] a_q, md_q, hi_q, lo_q;
  logic [XLEN-1:0] hi_n, lo_n;
  logic            sa, sb;
  logic [XLEN-1:0] ma, mb;
  logic [XLEN:0]   sum, shf;
  logic            ge;
  logic [XLEN-1:0] sub;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem;

  always_comb begin
    sa = a[XLEN-1] &
         (op inside {3'b001, 3'b010, 3'b100, 3'b110});
    sb = b[XLEN-1] &
         (op inside {3'b001, 3'b100, 3'b110});
    ma = sa ? -a : a;
    mb = sb ? -b : b;
  end

  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
    shf = {hi_q, lo_q[XLEN-1]};
    ge  = shf >= {1'b0, md_q};
    sub = shf[XLEN-1:0] - md_q;
    if (!op_q[2]) begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end else begin
      hi_n = ge ? sub : shf[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], ge};
    end
  end

  assign done = busy && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      negr_q <= 1'b0;
      div0_q <= 1'b0;
      a_q    <= '0;
      md_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      op_q   <= op;
      neg_q  <= sa ^ sb;
      negr_q <= sa;
      div0_q <= (b == '0);
      a_q    <= a;
      md_q   <= op[2] ? mb : ma;
      hi_q   <= '0;
      lo_q   <= op[2] ? ma : mb;
    end else if (busy) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
      cnt  <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  // Final step is taken combinationally so the result lands with done.
  always_comb begin
    prod = {hi_n, lo_n};
    if (neg_q) prod = -prod;
    quo = neg_q ? -lo_n : lo_n;
    rem = negr_q ? -hi_n : hi_n;
    if (div0_q) begin
      quo = '1;
      rem = a_q;
    end
    if (!op_q[2])
      res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                 : prod[2*XLEN-1:XLEN];
    else
      res = op_q[1] ? rem : quo;
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes and registered result.
// Define ALU_MULDIV_EN to add the iterative multiply/divide path.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_1,
  input  logic [XLEN-1:0] i_2,
  input  logic [4:0]      aluSel,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_flag
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] sc_res, md_res;
  logic            accept, sc_sel, md_fin;

  assign sh     = i_2[SHW-1:0];
  assign accept = i_valid && o_ready && !i_flush;

  always_comb begin
    sc_res = '0;
    unique case (aluSel)
      OP_AND:  sc_res = i_1 & i_2;
      OP_OR:   sc_res = i_1 | i_2;
      OP_XOR:  sc_res = i_1 ^ i_2;
      OP_ADD:  sc_res = i_1 + i_2;
      OP_SUB:  sc_res = i_1 - i_2;
      OP_PASS: sc_res = i_2;
      OP_SLL:  sc_res = i_1 << sh;
      OP_SRL:  sc_res = i_1 >> sh;
      OP_SRA:  sc_res = $signed(i_1) >>> sh;
      OP_SLLA: sc_res = i_1 << sh;
      OP_SLTU:
        sc_res = {{(XLEN-1){1'b0}}, i_1 < i_2};
      OP_SLT:
        sc_res = {{(XLEN-1){1'b0}},
                  $signed(i_1) < $signed(i_2)};
      default: sc_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  state_t state, state_n;
  logic   is_md, md_done;

  assign is_md = (aluSel[4:3] == MD_PFX);

  alu_muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (accept && is_md),
    .abort (i_flush),
    .op    (aluSel[2:0]),
    .a     (i_1),
    .b     (i_2),
    .done  (md_done),
    .res   (md_res)
  );

  assign o_ready = (state == IDLE) && (!o_valid || i_ready);
  assign sc_sel  = accept && !is_md;
  assign md_fin  = md_done && (state == BUSY);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept && is_md) state_n = BUSY;
      BUSY:    if (md_done) state_n = DONE;
      DONE:    if (i_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (i_flush) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
`else
  assign o_ready = !o_valid || i_ready;
  assign sc_sel  = accept;
  assign md_fin  = 1'b0;
  assign md_res  = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      result  <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (sc_sel) begin
      o_valid <= 1'b1;
      result  <= sc_res;
    end else if (md_fin) begin
      o_valid <= 1'b1;
      result  <= md_res;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  assign zero_flag = ~|result;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (XLEN 32 and 16).
// Multiply/divide expectations follow ALU_MULDIV_EN.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, i_flush;
  logic        o_valid, i_ready, zero_flag;
  logic [31:0] i_1, i_2, result;
  logic [4:0]  aluSel;

  logic        s_valid, s_oready, s_ovalid, s_zf;
  logic [15:0] s_1, s_2, s_res;
  logic [4:0]  s_sel;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_1(i_1), .i_2(i_2), .aluSel(aluSel),
    .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready),
    .result(result), .zero_flag(zero_flag)
  );

  alu_pipe #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst),
    .i_valid(s_valid), .o_ready(s_oready),
    .i_1(s_1), .i_2(s_2), .aluSel(s_sel),
    .i_flush(1'b0),
    .o_valid(s_ovalid), .i_ready(1'b1),
    .result(s_res), .zero_flag(s_zf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    i_valid = v;
    aluSel  = op;
    i_1     = a;
    i_2     = b;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (o_valid !== 1'b0) begin
      fails++; $display("FAIL rst_valid got %b want 0", o_valid);
    end
    checks++;
    if (result !== 32'h0) begin
      fails++; $display("FAIL rst_result got %h want 0", result);
    end
    checks++;
    if (zero_flag !== 1'b1 || s_zf !== 1'b1) begin
      fails++;
      $display("FAIL rst_zf got %b/%b want 1", zero_flag, s_zf);
    end
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_release rdy=%b vld=%b want 1/0",
               o_ready, o_valid);
    end
  endtask

  task automatic test_back_to_back;
    i_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'd7, 32'hFFFF_FFF9);
    tick;
    checks++;
    if (result !== 32'h0 || zero_flag !== 1'b1 ||
        o_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_add got %h zf=%b v=%b want 0 1 1",
               result, zero_flag, o_valid);
    end
    drive(1'b1, OP_SRA, 32'h8000_0000, 32'd4);
    tick;
    checks++;
    if (result !== 32'hF800_0000 || zero_flag !== 1'b0 ||
        o_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_sra got %h zf=%b v=%b want f8000000 0 1",
               result, zero_flag, o_valid);
    end
    i_valid = 1'b0;
    tick;
    checks++;
    if (o_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_drain got %b want 0", o_valid);
    end
  endtask

  task automatic test_backpressure;
    i_ready = 1'b0;
    drive(1'b1, OP_SUB, 32'd5, 32'd3);
    tick;
    drive(1'b1, OP_ADD, 32'd1, 32'd1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (result !== 32'd2 || o_valid !== 1'b1 ||
          o_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d got %h v=%b r=%b want 2 1 0",
                 k, result, o_valid, o_ready);
      end
      if (k < 3) tick;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick;
    checks++;
    if (o_valid !== 1'b0 || result !== 32'd2) begin
      fails++;
      $display("FAIL bp_release got %h v=%b want 2 0",
               result, o_valid);
    end
  endtask

  task automatic test_single_ops;
    vec_t v [13];
    v = '{
      '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200},
      '{OP_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F},
      '{OP_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555},
      '{OP_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE},
      '{OP_PASS, 32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
      '{OP_SLL,  32'd1,         32'd33,        32'd2},
      '{OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000},
      '{OP_SLLA, 32'd3,         32'h24,        32'h30},
      '{OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0},
      '{OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1},
      '{5'h05,   32'd5,         32'd5,         32'd0},
      '{5'h1F,   32'd5,         32'd5,         32'd0},
      '{OP_ADD,  32'hFFFF_FFFF, 32'd2,         32'd1}
    };
    i_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      drive(1'b1, v[k].op, v[k].a, v[k].b);
      tick;
      checks++;
      if (result !== v[k].exp || o_valid !== 1'b1 ||
          zero_flag !== (v[k].exp == 32'h0)) begin
        fails++;
        $display("FAIL op%0d sel=%h got %h zf=%b v=%b want %h",
                 k, v[k].op, result, zero_flag, o_valid, v[k].exp);
      end
    end
    i_valid = 1'b0;
    tick;
  endtask

`ifdef ALU_MULDIV_EN
  task automatic test_muldiv;
    vec_t v [14];
    int   lat;
    v = '{
      '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{OP_MUL,    32'd3,         32'd4,         32'd12},
      '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0},
      '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0},
      '{OP_REMU,   32'd9,         32'd0,         32'd9},
      '{OP_DIVU,   32'd9,         32'd0,         32'hFFFF_FFFF},
      '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
      '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
      '{OP_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF},
      '{OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB},
      '{OP_DIVU,   32'd100,       32'd7,         32'd14}
    };
    i_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      drive(1'b1, v[k].op, v[k].a, v[k].b);
      tick;
      i_valid = 1'b0;
      lat = 1;
      checks++;
      if (o_ready !== 1'b0) begin
        fails++; $display("FAIL md%0d_busy_rdy got %b want 0",
                          k, o_ready);
      end
      while (o_valid !== 1'b1 && lat < 40) begin
        tick;
        lat++;
      end
      checks++;
      if (lat != 33) begin
        fails++; $display("FAIL md%0d_latency got %0d want 33",
                          k, lat);
      end
      checks++;
      if (result !== v[k].exp) begin
        fails++; $display("FAIL md%0d sel=%h got %h want %h",
                          k, v[k].op, result, v[k].exp);
      end
      tick;
    end
  endtask
`else
  task automatic test_muldiv;
    i_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'd1, 32'd1);
    tick;
    checks++;
    if (result !== 32'd2) begin
      fails++; $display("FAIL nomd_pre got %h want 2", result);
    end
    drive(1'b1, OP_MUL, 32'd3, 32'd4);
    tick;
    checks++;
    if (result !== 32'd0 || zero_flag !== 1'b1 ||
        o_valid !== 1'b1) begin
      fails++;
      $display("FAIL nomd_mul got %h zf=%b v=%b want 0 1 1",
               result, zero_flag, o_valid);
    end
    drive(1'b1, OP_ADD, 32'd4, 32'd4);
    tick;
    drive(1'b1, OP_DIVU, 32'd9, 32'd0);
    tick;
    checks++;
    if (result !== 32'd0 || o_valid !== 1'b1) begin
      fails++;
      $display("FAIL nomd_divu got %h v=%b want 0 1",
               result, o_valid);
    end
    i_valid = 1'b0;
    tick;
  endtask
`endif

  task automatic test_flush;
    logic seen;
    i_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'd2, 32'd3);
    tick;
    checks++;
    if (result !== 32'd5 || o_valid !== 1'b1) begin
      fails++; $display("FAIL fl_pre got %h v=%b want 5 1",
                        result, o_valid);
    end
    i_flush = 1'b1;
    drive(1'b1, OP_ADD, 32'd1, 32'd1);
    tick;
    i_flush = 1'b0;
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 ||
        result !== 32'd5) begin
      fails++;
      $display("FAIL fl_prio got %h v=%b r=%b want 5 0 1",
               result, o_valid, o_ready);
    end
    i_ready = 1'b1;
`ifdef ALU_MULDIV_EN
    drive(1'b1, OP_DIV, 32'd100, 32'd7);
    tick;
    i_valid = 1'b0;
    repeat (9) tick;
    i_flush = 1'b1;
    tick;
    i_flush = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      fails++; $display("FAIL fl_div got v=%b r=%b want 0 1",
                        o_valid, o_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (o_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL fl_div_ghost got %b want 0", seen);
    end
`else
    seen = 1'b0;
    tick;
    if (o_valid !== 1'b0) seen = 1'b1;
    checks++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL fl_ghost got %b want 0", seen);
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic seen;
`ifdef ALU_MULDIV_EN
    i_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'd1, 32'd2);
    tick;
    drive(1'b1, OP_MUL, 32'd6, 32'd7);
    tick;
    i_valid = 1'b0;
    repeat (5) tick;
`else
    i_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'd1, 32'd2);
    tick;
    i_valid = 1'b0;
    tick;
`endif
    checks++;
    if (result !== 32'd3) begin
      fails++; $display("FAIL rm_pre got %h want 3", result);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || result !== 32'h0 ||
        zero_flag !== 1'b1) begin
      fails++;
      $display("FAIL rm_async got %h v=%b zf=%b want 0 0 1",
               result, o_valid, zero_flag);
    end
    tick;
    rst = 1'b0;
    i_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (o_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || o_ready !== 1'b1) begin
      fails++; $display("FAIL rm_after got v=%b r=%b want 0 1",
                        seen, o_ready);
    end
  endtask

  task automatic test_xlen16;
    s_valid = 1'b1;
    s_sel = OP_SLL; s_1 = 16'h0001; s_2 = 16'h0013;
    tick;
    checks++;
    if (s_res !== 16'h0008 || s_ovalid !== 1'b1) begin
      fails++; $display("FAIL x16_sll got %h v=%b want 0008 1",
                        s_res, s_ovalid);
    end
    s_sel = OP_SRA; s_1 = 16'h8000; s_2 = 16'h0004;
    tick;
    checks++;
    if (s_res !== 16'hF800) begin
      fails++; $display("FAIL x16_sra got %h want f800", s_res);
    end
    s_sel = OP_ADD; s_1 = 16'hFFFF; s_2 = 16'h0001;
    tick;
    checks++;
    if (s_res !== 16'h0000 || s_zf !== 1'b1) begin
      fails++; $display("FAIL x16_add got %h zf=%b want 0 1",
                        s_res, s_zf);
    end
    s_sel = OP_SLT; s_1 = 16'h8000; s_2 = 16'h0001;
    tick;
    checks++;
    if (s_res !== 16'h0001 || s_zf !== 1'b0) begin
      fails++; $display("FAIL x16_slt got %h zf=%b want 1 0",
                        s_res, s_zf);
    end
    s_valid = 1'b0;
    tick;
  endtask

  initial begin
    rst     = 1'b1;
    i_flush = 1'b0;
    i_ready = 1'b1;
    drive(1'b0, OP_AND, 32'h0, 32'h0);
    s_valid = 1'b0;
    s_sel   = OP_AND;
    s_1     = 16'h0;
    s_2     = 16'h0;
    test_reset;
    test_back_to_back;
    test_backpressure;
    test_single_ops;
    test_muldiv;
    test_flush;
    test_reset_mid;
    test_xlen16;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
